// File: rtl/gpi_rx_cond.sv
`default_nettype none
// ============================================================================
// Module      : gpi_rx_cond
// Description : GPI receive conditioner. It gates the pad receiver, synchronises
//               the pad data, applies a glitch filter, detects edges and raises
//               a sticky interrupt. The edge timestamp capture is enabled by
//               defining GPI_RX_COND_TIMESTAMP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gpi_rx_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_W      = 8,
    parameter int WARM_CYC    = 4,
    parameter int TS_W        = 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic              PAD_DI_I,
    input  logic              EN_I,
    output logic              IE_O,
    input  logic              POL_I,
    input  logic [FILT_W-1:0] FILT_LEN_I,
    input  logic [1:0]        EDGE_SEL_I,
    output logic              DAT_O,
    output logic              RISE_O,
    output logic              FALL_O,
    output logic              IRQ_O,
    input  logic              IRQ_CLR_I,
    output logic [TS_W-1:0]   TS_O,
    output logic              TS_VLD_O
);

    localparam logic [3:0] c_WARM_LAST = 4'(WARM_CYC - 1);

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_WARM = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic [FILT_W-1:0]   r_filt_cnt, w_filt_nxt;
    logic [3:0]          r_warm_cnt, w_warm_nxt;
    logic                r_ie, w_ie_nxt;
    logic                r_dat, w_dat_nxt;
    logic                r_rise, w_rise_nxt;
    logic                r_fall, w_fall_nxt;
    logic                r_irq;
    logic                w_s;
    logic                w_hit;

    // Synchroniser runs regardless of enable so data is settled at warm-up end
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) r_sync <= '0;
        else       r_sync <= {r_sync[SYNC_STAGES-2:0], PAD_DI_I};
    end

    assign w_s = r_sync[SYNC_STAGES-1] ^ POL_I;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) r_state <= ST_OFF;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ie_nxt    = r_ie;
        w_dat_nxt   = r_dat;
        w_rise_nxt  = 1'b0;
        w_fall_nxt  = 1'b0;
        w_filt_nxt  = r_filt_cnt;
        w_warm_nxt  = r_warm_cnt;
        case (r_state)
            ST_OFF: begin
                w_ie_nxt   = 1'b0;
                w_dat_nxt  = 1'b0;
                w_filt_nxt = '0;
                if (EN_I) begin
                    w_state_nxt = ST_WARM;
                    w_ie_nxt    = 1'b1;
                    w_warm_nxt  = '0;
                end
            end
            ST_WARM: begin
                if (!EN_I) begin
                    w_state_nxt = ST_OFF;
                    w_ie_nxt    = 1'b0;
                    w_dat_nxt   = 1'b0;
                    w_filt_nxt  = '0;
                end else if (r_warm_cnt == c_WARM_LAST) begin
                    // Initial load of the level is not reported as an edge
                    w_state_nxt = ST_RUN;
                    w_dat_nxt   = w_s;
                    w_filt_nxt  = '0;
                end else begin
                    w_warm_nxt = r_warm_cnt + 4'd1;
                end
            end
            ST_RUN: begin
                if (!EN_I) begin
                    w_state_nxt = ST_OFF;
                    w_ie_nxt    = 1'b0;
                    w_dat_nxt   = 1'b0;
                    w_filt_nxt  = '0;
                end else if (w_s == r_dat) begin
                    w_filt_nxt = '0;
                end else if (r_filt_cnt >= FILT_LEN_I) begin
                    // >= keeps a shrinking filter length from stalling the count
                    w_dat_nxt  = w_s;
                    w_filt_nxt = '0;
                    w_rise_nxt = w_s;
                    w_fall_nxt = ~w_s;
                end else begin
                    w_filt_nxt = r_filt_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_OFF;
                w_ie_nxt    = 1'b0;
                w_dat_nxt   = 1'b0;
                w_filt_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_ie       <= 1'b0;
            r_dat      <= 1'b0;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_filt_cnt <= '0;
            r_warm_cnt <= '0;
        end else begin
            r_ie       <= w_ie_nxt;
            r_dat      <= w_dat_nxt;
            r_rise     <= w_rise_nxt;
            r_fall     <= w_fall_nxt;
            r_filt_cnt <= w_filt_nxt;
            r_warm_cnt <= w_warm_nxt;
        end
    end

    assign w_hit = (r_rise & EDGE_SEL_I[0]) | (r_fall & EDGE_SEL_I[1]);

    // Set has priority over clear so no selected edge is ever lost
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I)          r_irq <= 1'b0;
        else if (w_hit)     r_irq <= 1'b1;
        else if (IRQ_CLR_I) r_irq <= 1'b0;
    end

`ifdef GPI_RX_COND_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts_cnt;
    logic [TS_W-1:0] r_ts;
    logic            r_ts_vld;

    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) r_ts_cnt <= '0;
        else       r_ts_cnt <= r_ts_cnt + 1'b1;
    end

    // First selected edge wins until software clears the capture
    always_ff @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) begin
            r_ts     <= '0;
            r_ts_vld <= 1'b0;
        end else if (w_hit && !r_ts_vld) begin
            r_ts     <= r_ts_cnt;
            r_ts_vld <= 1'b1;
        end else if (IRQ_CLR_I) begin
            r_ts_vld <= 1'b0;
        end
    end

    assign TS_O     = r_ts;
    assign TS_VLD_O = r_ts_vld;
`else
    assign TS_O     = '0;
    assign TS_VLD_O = 1'b0;
`endif

    assign IE_O   = r_ie;
    assign DAT_O  = r_dat;
    assign RISE_O = r_rise;
    assign FALL_O = r_fall;
    assign IRQ_O  = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_gpi_rx_cond.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpi_rx_cond
// Description : Directed vector bench for gpi_rx_cond (table plus corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpi_rx_cond;

    logic        CLK_I = 1'b0;
    logic        RST_I = 1'b1;
    logic        PAD_DI_I = 1'b0;
    logic        EN_I = 1'b0;
    logic        IE_O;
    logic        POL_I = 1'b0;
    logic [7:0]  FILT_LEN_I = 8'd3;
    logic [1:0]  EDGE_SEL_I = 2'b00;
    logic        DAT_O;
    logic        RISE_O;
    logic        FALL_O;
    logic        IRQ_O;
    logic        IRQ_CLR_I = 1'b0;
    logic [15:0] TS_O;
    logic        TS_VLD_O;

    int n_chk = 0;
    int n_err = 0;

    gpi_rx_cond #(
        .SYNC_STAGES(2), .FILT_W(8), .WARM_CYC(4), .TS_W(16)
    ) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .PAD_DI_I(PAD_DI_I), .EN_I(EN_I),
        .IE_O(IE_O), .POL_I(POL_I), .FILT_LEN_I(FILT_LEN_I),
        .EDGE_SEL_I(EDGE_SEL_I), .DAT_O(DAT_O), .RISE_O(RISE_O),
        .FALL_O(FALL_O), .IRQ_O(IRQ_O), .IRQ_CLR_I(IRQ_CLR_I),
        .TS_O(TS_O), .TS_VLD_O(TS_VLD_O)
    );

    always #5 CLK_I = ~CLK_I;

`ifdef GPI_RX_COND_TIMESTAMP_EN
    logic [15:0] tb_ts;
    always @(posedge CLK_I or posedge RST_I) begin
        if (RST_I) tb_ts <= 16'd0;
        else       tb_ts <= tb_ts + 16'd1;
    end
`endif

    typedef struct {
        logic       pad;
        logic       en;
        logic [1:0] esel;
        logic       clr;
        logic       e_ie;
        logic       e_dat;
        logic       e_rise;
        logic       e_fall;
        logic       e_irq;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic pad, input logic en, input logic [1:0] esel,
                       input logic clr, input logic e_ie, input logic e_dat,
                       input logic e_rise, input logic e_fall, input logic e_irq,
                       input int rep);
        vec_t v;
        v = '{pad, en, esel, clr, e_ie, e_dat, e_rise, e_fall, e_irq};
        for (int k = 0; k < rep; k++) vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_I);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        // FILT_LEN=3, POL=0; each row: inputs, one edge, expected outputs
        add(1, 1, 2'b00, 0,  1, 0, 0, 0, 0,  4);  // warm-up
        add(1, 1, 2'b00, 0,  1, 1, 0, 0, 0,  1);  // initial load, no rise
        add(0, 1, 2'b00, 0,  1, 1, 0, 0, 0,  5);
        add(0, 1, 2'b00, 0,  1, 0, 0, 1, 0,  1);  // fall 6 edges later
        add(1, 1, 2'b00, 0,  1, 0, 0, 0, 0,  1);
        add(1, 1, 2'b10, 0,  1, 0, 0, 0, 0,  4);
        add(1, 1, 2'b10, 0,  1, 1, 1, 0, 0,  1);  // rise 6 edges later
        add(1, 1, 2'b10, 0,  1, 1, 0, 0, 0,  1);  // rise not selected
        add(0, 1, 2'b10, 0,  1, 1, 0, 0, 0,  3);  // 3-cycle glitch
        add(1, 1, 2'b10, 0,  1, 1, 0, 0, 0,  4);
        add(0, 1, 2'b10, 0,  1, 1, 0, 0, 0,  4);  // 4-cycle pulse
        add(1, 1, 2'b10, 0,  1, 1, 0, 0, 0,  1);
        add(1, 1, 2'b10, 0,  1, 0, 0, 1, 0,  1);
        add(1, 1, 2'b10, 0,  1, 0, 0, 0, 1,  3);  // fall sets irq
        add(1, 1, 2'b10, 0,  1, 1, 1, 0, 1,  1);
        add(1, 1, 2'b10, 0,  1, 1, 0, 0, 1,  1);
        add(1, 1, 2'b10, 1,  1, 1, 0, 0, 0,  1);  // plain clear
        add(0, 1, 2'b10, 0,  1, 1, 0, 0, 0,  5);
        add(0, 1, 2'b10, 0,  1, 0, 0, 1, 0,  1);
        add(0, 1, 2'b10, 1,  1, 0, 0, 0, 1,  1);  // set beats clear
        add(0, 1, 2'b10, 0,  1, 0, 0, 0, 1,  1);
        add(1, 1, 2'b10, 0,  1, 0, 0, 0, 1,  5);
        add(1, 1, 2'b10, 0,  1, 1, 1, 0, 1,  1);
        add(1, 0, 2'b10, 0,  0, 0, 0, 0, 1,  2);  // disable: no fall, irq kept

        // Reset values while reset is held
        ticks(3);
        chk("rst ie", IE_O, 0);
        chk("rst dat", DAT_O, 0);
        chk("rst rise", RISE_O, 0);
        chk("rst fall", FALL_O, 0);
        chk("rst irq", IRQ_O, 0);
        chk("rst ts", TS_O, 0);
        chk("rst vld", TS_VLD_O, 0);
        RST_I = 1'b0;

        foreach (vq[i]) begin
            PAD_DI_I   = vq[i].pad;
            EN_I       = vq[i].en;
            EDGE_SEL_I = vq[i].esel;
            IRQ_CLR_I  = vq[i].clr;
            tick();
            chk($sformatf("v%0d ie", i), IE_O, vq[i].e_ie);
            chk($sformatf("v%0d dat", i), DAT_O, vq[i].e_dat);
            chk($sformatf("v%0d rise", i), RISE_O, vq[i].e_rise);
            chk($sformatf("v%0d fall", i), FALL_O, vq[i].e_fall);
            chk($sformatf("v%0d irq", i), IRQ_O, vq[i].e_irq);
        end
        IRQ_CLR_I = 1'b0;

        // Inverted polarity, no filtering, rise-only interrupt
        PAD_DI_I = 1'b0; EN_I = 1'b1; POL_I = 1'b1; FILT_LEN_I = 8'd0;
        EDGE_SEL_I = 2'b01; IRQ_CLR_I = 1'b1;
        tick();
        chk("pol ie", IE_O, 1);
        chk("pol irq clr", IRQ_O, 0);
        IRQ_CLR_I = 1'b0;
        ticks(3);
        chk("pol warm dat", DAT_O, 0);
        tick();
        chk("pol load dat", DAT_O, 1);
        chk("pol load rise", RISE_O, 0);
        PAD_DI_I = 1'b1;
        ticks(2);
        chk("f0 no fall yet", FALL_O, 0);
        tick();
        chk("f0 fall", FALL_O, 1);
        chk("f0 dat", DAT_O, 0);
        tick();
        chk("f0 fall unselected", IRQ_O, 0);
        PAD_DI_I = 1'b0;
        ticks(3);
        chk("f0 rise", RISE_O, 1);
        chk("f0 rise dat", DAT_O, 1);
        tick();
        chk("f0 rise irq", IRQ_O, 1);
        chk("f0 rise pulse end", RISE_O, 0);

`ifdef GPI_RX_COND_TIMESTAMP_EN
        begin
            int guard;
            guard = 0;
            EDGE_SEL_I = 2'b11;
            while (tb_ts != 16'hFFFB && guard < 70000) begin
                tick();
                guard++;
            end
            if (guard >= 70000) begin
                n_chk++;
                n_err++;
                $display("FAIL ts wait: got timeout expected counter FFFB");
            end
            PAD_DI_I = 1'b1;
            ticks(3);
            chk("ts fall", FALL_O, 1);
            tick();
            chk("ts first", TS_O, 16'hFFFE);
            chk("ts first vld", TS_VLD_O, 1);
            PAD_DI_I = 1'b0;
            ticks(3);
            chk("ts second rise", RISE_O, 1);
            tick();
            chk("ts kept", TS_O, 16'hFFFE);
            chk("ts kept vld", TS_VLD_O, 1);
            IRQ_CLR_I = 1'b1;
            tick();
            IRQ_CLR_I = 1'b0;
            chk("ts clr vld", TS_VLD_O, 0);
            chk("ts clr irq", IRQ_O, 0);
        end
`else
        chk("ts tied", TS_O, 0);
        chk("ts vld tied", TS_VLD_O, 0);
`endif

        // Asynchronous reset in the middle of a cycle
        @(posedge CLK_I);
        #3 RST_I = 1'b1;
        #1;
        chk("async rst ie", IE_O, 0);
        chk("async rst dat", DAT_O, 0);
        chk("async rst irq", IRQ_O, 0);
        chk("async rst vld", TS_VLD_O, 0);
        tick();
        chk("held rst ie", IE_O, 0);
        RST_I = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
